// File: rtl/frame_pkg.sv
// Shared frame definitions for the 11-bit serial link (transmitter and receiver).
// Optional feature macro: FRAME_SER_PARITY_EN (bit9 carries even parity instead of a second stop bit).
package frame_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FRAME_W    = 11;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned LEVEL_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BIT_IDX_W  = 4;
  localparam int unsigned CNT_W      = 6;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic [FRAME_W-1:0] IDLE_FRAME = 11'h7FF;

  localparam int unsigned DATA_LSB_POS = 1;
  localparam int unsigned BIT9_POS     = 9;
  localparam int unsigned STOP_POS     = 10;

  typedef logic [DATA_W-1:0] payload_t;

  // ST_LOAD: the coming edge loads a new frame; ST_SHIFT: the coming edge shifts one bit.
  typedef enum logic {ST_LOAD, ST_SHIFT} tx_state_t;

  // Assemble a data frame, bit 0 is transmitted first.
  function automatic logic [FRAME_W-1:0] build_frame(input payload_t data);
    logic [FRAME_W-1:0] f;
    f                        = IDLE_FRAME;
    f[0]                     = START_BIT;
    f[DATA_LSB_POS +: DATA_W] = data;
`ifdef FRAME_SER_PARITY_EN
    f[BIT9_POS]              = ^data;
`else
    f[BIT9_POS]              = STOP_BIT;
`endif
    f[STOP_POS]              = STOP_BIT;
    return f;
  endfunction

endpackage

// File: rtl/frame_serializer_tx_if.sv
// Byte stream valid/ready handshake into the frame serializer.
interface frame_serializer_tx_if;

  logic [frame_pkg::DATA_W-1:0] in_data;
  logic                         in_valid;
  logic                         in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/frame_tx_fifo.sv
// Show-ahead synchronous FIFO with level count and a registered ready flag.
module frame_tx_fifo
  import frame_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  payload_t             wr_data,
  output payload_t             rd_data,
  output logic [LEVEL_W-1:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  payload_t            mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [LEVEL_W-1:0]  count_d;
  logic                push_ok;
  logic                pop_ok;

  assign full    = (count == LEVEL_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Next level: simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count + LEVEL_W'(1);
      2'b01:   count_d = count - LEVEL_W'(1);
      default: count_d = count;
    endcase
  end

  // Pointers, level and ready; ready stays low through reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_d;
      ready <= (count_d != LEVEL_W'(DEPTH));
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/frame_serializer_tx.sv
// Continuous 11-bit frame serializer; idle frames fill slots with no buffered byte.
// Optional feature macro: FRAME_SER_PARITY_EN (handled in frame_pkg::build_frame).
module frame_serializer_tx
  import frame_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  frame_serializer_tx_if.slave in_bus,
  output logic                 tx,
  output logic                 frame_start,
  output logic                 frame_data,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic [LEVEL_W-1:0]   fifo_level
);

  tx_state_t              state, state_d;
  logic [BIT_IDX_W-1:0]   bit_idx, bit_idx_d;
  logic [FRAME_W-1:0]     sr, sr_d;
  logic                   frame_start_d;
  logic                   frame_data_d;
  logic [CNT_W-1:0]       frame_cnt_d;
  logic                   load_c;
  payload_t               head;
  logic                   fifo_full;
  logic                   fifo_empty;

  frame_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (in_bus.in_valid),
    .pop     (load_c),
    .wr_data (in_bus.in_data),
    .rd_data (head),
    .count   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .ready   (in_bus.in_ready)
  );

  assign tx = sr[0];

  // State and datapath registers; reset parks the line at 1 and arms the first load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_LOAD;
      bit_idx     <= '0;
      sr          <= IDLE_FRAME;
      frame_start <= 1'b0;
      frame_data  <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state       <= state_d;
      bit_idx     <= bit_idx_d;
      sr          <= sr_d;
      frame_start <= frame_start_d;
      frame_data  <= frame_data_d;
      frame_cnt   <= frame_cnt_d;
    end
  end

  // Next state: load a frame (data or idle) at each boundary, otherwise shift right.
  always_comb begin
    state_d       = state;
    bit_idx_d     = bit_idx;
    sr_d          = {STOP_BIT, sr[FRAME_W-1:1]};
    frame_start_d = 1'b0;
    frame_data_d  = frame_data;
    frame_cnt_d   = frame_cnt;
    load_c        = 1'b0;
    case (state)
      ST_LOAD: begin
        load_c        = 1'b1;
        sr_d          = fifo_empty ? IDLE_FRAME : build_frame(head);
        frame_start_d = 1'b1;
        frame_data_d  = !fifo_empty;
        frame_cnt_d   = frame_cnt + CNT_W'(1);
        bit_idx_d     = '0;
        state_d       = ST_SHIFT;
      end
      ST_SHIFT: begin
        bit_idx_d = bit_idx + BIT_IDX_W'(1);
        if (bit_idx == BIT_IDX_W'(FRAME_W - 2)) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  logic unused_ok;
  assign unused_ok = fifo_full;

endmodule

// File: tb/tb_frame_serializer_tx.sv
// Directed bench for frame_serializer_tx: reset, single byte, back-pressure, load-edge push,
// frame counter wrap and mid-frame reset.
module tb_frame_serializer_tx;

  logic       clk;
  logic       rst_n;
  logic       tx;
  logic       frame_start;
  logic       frame_data;
  logic [5:0] frame_cnt;
  logic [2:0] fifo_level;

  int unsigned checks = 0;
  int unsigned errors = 0;

  frame_serializer_tx_if bus ();

  frame_serializer_tx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_bus      (bus),
    .tx          (tx),
    .frame_start (frame_start),
    .frame_data  (frame_data),
    .frame_cnt   (frame_cnt),
    .fifo_level  (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: stop, bit9, data, start (MSB..LSB).
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic p;
`ifdef FRAME_SER_PARITY_EN
    p = ^b;
`else
    p = 1'b1;
`endif
    return {1'b1, p, b, 1'b0};
  endfunction

  // Receiver model: shift 11 line bits in from the top, first bit ends at [0].
  task automatic collect(output logic [10:0] f);
    logic [10:0] rx;
    rx = '0;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) tick();
      rx = {tx, rx[10:1]};
    end
    f = rx;
  endtask

  initial begin
    logic [10:0] fr;
    logic [7:0]  burst [4];
    int unsigned cnt_exp;

    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h3C; burst[3] = 8'h44;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // 1: reset
    tick(); tick(); tick();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    rst_n = 1'b1;
    tick();
    check("first_start", 32'(frame_start), 32'd1);
    check("first_cnt", 32'(frame_cnt), 32'd1);
    check("first_ready", 32'(bus.in_ready), 32'd1);
    check("first_data", 32'(frame_data), 32'd0);
    collect(fr);
    check("first_idle_frame", 32'(fr), 32'h7FF);

    // 2: single byte pushed mid-frame
    tick();
    check("f2_start", 32'(frame_start), 32'd1);
    bus.in_valid = 1'b1; bus.in_data = 8'hA5;
    tick();
    bus.in_valid = 1'b0;
    check("f2_level", 32'(fifo_level), 32'd1);
    check("f2_start_low", 32'(frame_start), 32'd0);
    for (int i = 0; i < 9; i++) tick();
    tick();
    check("a5_start", 32'(frame_start), 32'd1);
    check("a5_data", 32'(frame_data), 32'd1);
    check("a5_level", 32'(fifo_level), 32'd0);
    collect(fr);
`ifdef FRAME_SER_PARITY_EN
    check("a5_frame", 32'(fr), 32'h54A);
`else
    check("a5_frame", 32'(fr), 32'h74A);
`endif

    // 3: five back-to-back pushes into a depth-4 FIFO
    tick();
    check("f4_idle_data", 32'(frame_data), 32'd0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = burst[i];
      tick();
      check("burst_level", 32'(fifo_level), 32'(i + 1));
    end
    check("burst_full_ready", 32'(bus.in_ready), 32'd0);
    bus.in_data = 8'h55;
    tick();
    bus.in_valid = 1'b0;
    check("burst_overflow_level", 32'(fifo_level), 32'd4);
    check("burst_overflow_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      check("burst_start", 32'(frame_start), 32'd1);
      check("burst_data", 32'(frame_data), 32'd1);
      check("burst_pop_level", 32'(fifo_level), 32'(3 - k));
      collect(fr);
      check("burst_frame", 32'(fr), 32'(exp_frame(burst[k])));
    end
    tick();
    check("post_burst_data", 32'(frame_data), 32'd0);
    collect(fr);
    check("post_burst_idle", 32'(fr), 32'h7FF);

    // 4: push on the load edge with the FIFO empty
    bus.in_valid = 1'b1; bus.in_data = 8'hC3;
    tick();
    bus.in_valid = 1'b0;
    check("edge_start", 32'(frame_start), 32'd1);
    check("edge_data", 32'(frame_data), 32'd0);
    check("edge_level", 32'(fifo_level), 32'd1);
    collect(fr);
    check("edge_idle_frame", 32'(fr), 32'h7FF);
    tick();
    check("edge_next_data", 32'(frame_data), 32'd1);
    check("edge_next_level", 32'(fifo_level), 32'd0);
    collect(fr);
    check("edge_next_frame", 32'(fr), 32'(exp_frame(8'hC3)));

    // 5: 70 frames, counter wrap and strict 11-cycle spacing
    check("cnt_before_run", 32'(frame_cnt), 32'd11);
    cnt_exp = 11;
    for (int j = 1; j <= 770; j++) begin
      tick();
      if ((j - 1) % 11 == 0) begin
        cnt_exp = (cnt_exp + 1) % 64;
        check("run_start_hi", 32'(frame_start), 32'd1);
        check("run_cnt", 32'(frame_cnt), 32'(cnt_exp));
      end else begin
        check("run_start_lo", 32'(frame_start), 32'd0);
      end
    end
    check("run_cnt_end", 32'(frame_cnt), 32'd17);

    // 6: reset at bit 5 with two bytes queued
    tick();
    bus.in_valid = 1'b1; bus.in_data = 8'h12;
    tick();
    bus.in_data = 8'h34;
    tick();
    bus.in_valid = 1'b0;
    check("mid_level", 32'(fifo_level), 32'd2);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_cnt", 32'(frame_cnt), 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    check("mid_rel_start", 32'(frame_start), 32'd1);
    check("mid_rel_cnt", 32'(frame_cnt), 32'd1);
    check("mid_rel_data", 32'(frame_data), 32'd0);
    collect(fr);
    check("mid_rel_idle0", 32'(fr), 32'h7FF);
    tick();
    check("mid_rel_data1", 32'(frame_data), 32'd0);
    collect(fr);
    check("mid_rel_idle1", 32'(fr), 32'h7FF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
